// File: rtl/cnt_fp_sync.sv
// Clocked counter that emits its count as four-phase dual-rail tokens (rail[1]=true, rail[0]=false).
// Optional load port under CNT_FP_LOAD_EN. States: IDLE spacer/no token | DATA codeword held | NULL spacer, await ack low.
module cnt_fp_sync #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int MODULO      = 0,
  parameter int INIT        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   ack_i,
`ifdef CNT_FP_LOAD_EN
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
`endif
  output logic [WIDTH-1:0][1:0]  out,
  output logic [1:0]             wrap,
  output logic                   busy
);

  localparam logic [WIDTH:0]   M_W    = (MODULO == 0) ? {1'b1, {WIDTH{1'b0}}} : (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  localparam int               PW     = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        count_q;
  logic [WIDTH-1:0]        cnt_d;
  logic [WIDTH-1:0][1:0]   out_q;
  logic [1:0]              wrap_q;
  logic                    busy_q;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic [PW-1:0]           prime_q;
  logic                    ack_s;

  function automatic logic [WIDTH:0] sum_of(input logic [WIDTH-1:0] v);
    return {1'b0, v} + STEP_W;
  endfunction

  function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = sum_of(v);
    return (s >= M_W) ? WIDTH'(s - M_W) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0][1:0] enc(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0][1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = {v[i], ~v[i]};
    return r;
  endfunction

  function automatic logic [1:0] wrap_enc(input logic [WIDTH-1:0] v);
    logic w;
    w = (sum_of(v) >= M_W);
    return {w, ~w};
  endfunction

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign out   = out_q;
  assign wrap  = wrap_q;
  assign busy  = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_sync_q <= '0;
    else     ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
  end

  // The synchroniser resets to 0, so hold off the first token until it has seen the real ack level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                prime_q <= PW'(SYNC_STAGES);
    else if (prime_q != '0) prime_q <= prime_q - 1'b1;
  end

  always_comb begin
    cnt_d = count_q;
    if (state_q == S_NULL) cnt_d = next_of(count_q);
`ifdef CNT_FP_LOAD_EN
    if (load && (state_q != S_DATA))
      cnt_d = ({1'b0, load_val} >= M_W) ? WIDTH'({1'b0, load_val} - M_W) : load_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= INIT_W;
      out_q   <= '0;
      wrap_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_q <= cnt_d;
          if (en && !ack_s && (prime_q == '0)) begin
            state_q <= S_DATA;
            out_q   <= enc(cnt_d);
            wrap_q  <= wrap_enc(cnt_d);
            busy_q  <= 1'b1;
          end
        end
        S_DATA: begin
          if (ack_s) begin
            state_q <= S_NULL;
            out_q   <= '0;
            wrap_q  <= '0;
          end
        end
        S_NULL: begin
          if (!ack_s) begin
            count_q <= cnt_d;
            if (en) begin
              state_q <= S_DATA;
              out_q   <= enc(cnt_d);
              wrap_q  <= wrap_enc(cnt_d);
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          out_q   <= '0;
          wrap_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_fp_sync.sv
// Bench for cnt_fp_sync: two instances (mod 16 step 1, mod 10 step 3) checked against a token-level model.
module tb_cnt_fp_sync;

  logic clk, rst, en;
  logic hold, hold_val;
  logic [1:0] ack_auto;
  logic ack_a, ack_b;
  logic [3:0][1:0] out_a, out_b;
  logic [1:0] wrap_a, wrap_b;
  logic busy_a, busy_b;

  int vectors = 0;
  int miscompares = 0;

  int stp [2] = '{1, 3};
  int modm [2] = '{16, 10};
  int seq_a [17] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0};
  int seq_b [8]  = '{0,3,6,9,2,5,8,1};
  int wrp_b [8]  = '{0,0,0,1,0,0,1,0};

  int exp_val [2];
  int in_tok [2];
  int tok_idx [2];
  int tok_total [2];
  int dly [2];

  assign ack_a = hold ? hold_val : ack_auto[0];
  assign ack_b = hold ? hold_val : ack_auto[1];

  cnt_fp_sync #(.WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ack_i(ack_a),
`ifdef CNT_FP_LOAD_EN
    .load(1'b0), .load_val(4'd0),
`endif
    .out(out_a), .wrap(wrap_a), .busy(busy_a));

  cnt_fp_sync #(.WIDTH(4), .MODULO(10), .STEP(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ack_i(ack_b),
`ifdef CNT_FP_LOAD_EN
    .load(1'b0), .load_val(4'd0),
`endif
    .out(out_b), .wrap(wrap_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [7:0] o);
    int v = 0;
    for (int j = 0; j < 4; j++) if (o[2*j+1]) v += (1 << j);
    return v;
  endfunction

  function automatic logic is_cw(input logic [7:0] o);
    logic r = 1'b1;
    for (int j = 0; j < 4; j++) if (!(o[2*j+1] ^ o[2*j])) r = 1'b0;
    return r;
  endfunction

  task automatic model_check(input int k, input logic [7:0] o, input logic [1:0] w, input logic b);
    int n11, v, ew, lv, lw;
    if (rst) begin
      chk("rst_out", int'(o), 0);
      chk("rst_wrap", int'(w), 0);
      chk("rst_busy", int'(b), 0);
      exp_val[k] = 0; in_tok[k] = 0; tok_idx[k] = 0;
      return;
    end
    n11 = 0;
    for (int j = 0; j < 4; j++) if (o[2*j+1] && o[2*j]) n11++;
    chk("no_rail_11", n11, 0);
    chk("shape", int'(is_cw(o) || (o == 8'd0)), 1);
    if (is_cw(o)) begin
      v  = dec(o);
      ew = ((exp_val[k] + stp[k]) >= modm[k]) ? 2 : 1;
      chk("busy_in_data", int'(b), 1);
      if (!in_tok[k]) begin
        chk(k == 0 ? "tok_val_a" : "tok_val_b", v, exp_val[k]);
        chk(k == 0 ? "tok_wrap_a" : "tok_wrap_b", int'(w), ew);
        lv = -1; lw = 0;
        if (k == 0 && tok_idx[k] < 17) begin lv = seq_a[tok_idx[k]]; lw = (tok_idx[k] == 15) ? 2 : 1; end
        if (k == 1 && tok_idx[k] < 8)  begin lv = seq_b[tok_idx[k]]; lw = wrp_b[tok_idx[k]] ? 2 : 1; end
        if (lv >= 0) begin
          chk(k == 0 ? "lit_seq_a" : "lit_seq_b", v, lv);
          chk(k == 0 ? "lit_wrap_a" : "lit_wrap_b", int'(w), lw);
        end
        in_tok[k] = 1;
        tok_total[k]++;
      end else begin
        chk("data_stable", v, exp_val[k]);
        chk("wrap_stable", int'(w), ew);
      end
    end else begin
      chk("wrap_spacer", int'(w), 0);
      if (in_tok[k]) begin
        in_tok[k]  = 0;
        exp_val[k] = (exp_val[k] + stp[k]) % modm[k];
        tok_idx[k]++;
      end
    end
  endtask

  initial begin
    exp_val = '{0, 0}; in_tok = '{0, 0}; tok_idx = '{0, 0}; tok_total = '{0, 0};
    forever begin
      @(negedge clk);
      model_check(0, out_a, wrap_a, busy_a);
      model_check(1, out_b, wrap_b, busy_b);
    end
  end

  // Four-phase consumer: ack follows the data/spacer state after a random 0..4 cycle delay.
  initial begin
    ack_auto = 2'b00; dly = '{0, 0};
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        logic cw;
        cw = (i == 0) ? (out_a != 8'd0) : (out_b != 8'd0);
        if (rst) begin
          ack_auto[i] = 1'b0; dly[i] = 0;
        end else if (cw != ack_auto[i]) begin
          if (dly[i] == 0) begin
            ack_auto[i] = cw;
            dly[i] = $urandom_range(0, 4);
          end else dly[i]--;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(busy_a == 0 && busy_b == 0 && ack_auto == 2'b00)) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", int'(n < budget), 1);
  endtask

  initial begin
    int t0a, t0b, n;
    rst = 1'b1; en = 1'b0; hold = 1'b0; hold_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_a", int'(out_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    rst = 1'b0;

    repeat (800) begin
      @(posedge clk); #1;
      en = ($urandom_range(0, 3) != 0);
    end

    // Single en pulse with ack held low: one long token, then back to idle.
    @(posedge clk); #1; en = 1'b0;
    wait_idle(300);
    repeat (4) @(negedge clk);
    hold = 1'b1; hold_val = 1'b0;
    t0a = tok_total[0]; t0b = tok_total[1];
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("latency_a", int'(is_cw(out_a)), 1);
    chk("latency_b", int'(is_cw(out_b)), 1);
    repeat (22) begin
      @(negedge clk);
      chk("held_busy_a", int'(busy_a), 1);
      chk("held_val_a", dec(out_a), exp_val[0]);
      chk("held_val_b", dec(out_b), exp_val[1]);
    end
    hold = 1'b0;
    wait_idle(300);
    chk("single_tok_a", tok_total[0] - t0a, 1);
    chk("single_tok_b", tok_total[1] - t0b, 1);

    // ack high across reset release: no token until ack seen low through the synchroniser.
    @(negedge clk);
    rst = 1'b1; hold = 1'b1; hold_val = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ackhi_spacer_a", int'(out_a), 0);
      chk("ackhi_spacer_b", int'(out_b), 0);
    end
    hold_val = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("sync_wait_a", int'(out_a), 0);
    end
    @(negedge clk);
    chk("first_tok_cw_a", int'(is_cw(out_a)), 1);
    chk("first_tok_a", dec(out_a), 0);
    chk("first_tok_b", dec(out_b), 0);
    hold = 1'b0;

    // Asynchronous reset while A is showing 5.
    n = 0;
    while (n < 2000 && !(is_cw(out_a) && dec(out_a) == 5)) begin
      @(negedge clk); n++;
    end
    chk("reach_5_timeout", int'(n < 2000), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", int'(out_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_wrap", int'(wrap_a), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 100 && !is_cw(out_a)) begin
      @(negedge clk); n++;
    end
    chk("post_rst_timeout", int'(n < 100), 1);
    chk("post_rst_first", dec(out_a), 0);

    repeat (300) begin
      @(posedge clk); #1;
      en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
